memoria_up_drain: RTL and testbench

- Reader/consumer for the 16-entry "up" press-count memory in the RTC adjust path.
- Sweeps each address: reads the pending press count and erases it, but only when the count is nonzero.
- Offers each nonzero count to the RTC write sequencer over a valid/ready handshake.
- Avoids double-counting when a new press on the same address collides with the erase.

---
 rtl/memoria_up_drain_pkg.sv | 17 +
 rtl/memoria_up_drain_if.sv | 29 ++
 rtl/memoria_up_drain_bcd.sv | 33 +++
 rtl/memoria_up_drain.sv | 99 +++++++++
 tb/tb_memoria_up_drain.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memoria_up_drain_pkg.sv
// Shared constants and state type for the "up" press-count drain.
package memoria_up_pkg;

   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_ADDR_W   = 4;
   localparam int DEF_DATA_W   = 8;
   localparam int BCD_SAT      = 99;

   typedef enum logic [2:0] {
      IDLE,
      SET,
      CAP,
      OFFER,
      NEXT
   } state_t;

endpackage

// File: rtl/memoria_up_drain_if.sv
// Memory read/erase port plus the adjustment offer handshake toward the RTC write sequencer.
interface memoria_up_drain_if
   import memoria_up_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [ADDR_W-1:0] addrm;
   logic              erase;
   logic [DATA_W-1:0] dato_up;
   logic              up_snoop;
   logic [ADDR_W-1:0] addr_snoop;
   logic              adj_valid;
   logic [ADDR_W-1:0] adj_addr;
   logic [DATA_W-1:0] adj_count;
   logic              adj_ready;

   modport master (
      output addrm, erase, adj_valid, adj_addr, adj_count,
      input  dato_up, up_snoop, addr_snoop, adj_ready
   );

   modport slave (
      input  addrm, erase, adj_valid, adj_addr, adj_count,
      output dato_up, up_snoop, addr_snoop, adj_ready
   );

endinterface

// File: rtl/memoria_up_drain_bcd.sv
// Binary to packed BCD converter saturating at 99; only built when UP_DRAIN_BCD_EN is defined.
`ifdef UP_DRAIN_BCD_EN
module up_count_bcd
   import memoria_up_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] i_bin,
   output logic [7:0]        o_bcd
);

   logic [6:0] w_sat;
   logic [6:0] w_ones;
   logic [3:0] w_tens;

   assign w_sat = (i_bin > DATA_W'(BCD_SAT)) ? 7'(BCD_SAT) : 7'(i_bin);

   // Repeated subtraction of ten; nine steps cover every value up to 99.
   always_comb begin
      w_ones = w_sat;
      w_tens = 4'd0;
      for (int k = 0; k < 9; k++) begin
         if (w_ones >= 7'd10) begin
            w_ones = w_ones - 7'd10;
            w_tens = w_tens + 4'd1;
         end
      end
   end

   assign o_bcd = {w_tens, 4'(w_ones)};

endmodule
`endif

// File: rtl/memoria_up_drain.sv
// Sweeps the up press-count memory, erasing and offering each nonzero count to the RTC sequencer.
// Define UP_DRAIN_BCD_EN to present counts as saturated packed BCD instead of raw binary.
module memoria_up_drain
   import memoria_up_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   memoria_up_drain_if.master  bus,
   output logic                sweep_done
);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_count;
   logic              r_sweep_done;
   logic              w_collision;
   logic              w_last;
   logic              w_capture;
   logic [DATA_W-1:0] w_count_fmt;

   // A press landing on idx while its value is on dato_up would be lost by the erase, so retry.
   assign w_collision = bus.up_snoop && (bus.addr_snoop == r_idx);
   assign w_last      = (r_idx == ADDR_W'(NUM_REGS - 1));
   assign w_capture   = (r_state == CAP) && !w_collision && (bus.dato_up != '0);

`ifdef UP_DRAIN_BCD_EN
   logic [7:0] w_bcd;

   up_count_bcd #(.DATA_W(DATA_W)) u_bcd (
      .i_bin (bus.dato_up),
      .o_bcd (w_bcd)
   );

   assign w_count_fmt = DATA_W'(w_bcd);
`else
   assign w_count_fmt = bus.dato_up;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (enable) w_next = SET;
         SET:     w_next = CAP;
         CAP: begin
            if (w_collision)              w_next = SET;
            else if (bus.dato_up == '0)   w_next = NEXT;
            else                          w_next = OFFER;
         end
         OFFER:   if (bus.adj_ready) w_next = NEXT;
         NEXT:    w_next = (w_last && !enable) ? IDLE : SET;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idx <= '0;
      end else if (r_state == IDLE && enable) begin
         r_idx <= '0;
      end else if (r_state == NEXT) begin
         r_idx <= w_last ? '0 : r_idx + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr  <= '0;
         r_count <= '0;
      end else if (w_capture) begin
         r_addr  <= r_idx;
         r_count <= w_count_fmt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_sweep_done <= 1'b0;
      else       r_sweep_done <= (r_state == NEXT) && w_last;
   end

   assign bus.addrm     = r_idx;
   assign bus.erase     = w_capture;
   assign bus.adj_valid = (r_state == OFFER);
   assign bus.adj_addr  = r_addr;
   assign bus.adj_count = r_count;
   assign sweep_done    = r_sweep_done;

endmodule

// File: tb/tb_memoria_up_drain.sv
// Bench for memoria_up_drain: press-ledger model of the memory plus directed and random sweeps.
module tb_memoria_up_drain;
   import memoria_up_pkg::*;

   localparam int NR = DEF_NUM_REGS;

   logic clk = 1'b0;
   logic reset;
   logic enable;
   logic sweep_done;

   memoria_up_drain_if bus ();

   memoria_up_drain dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .sweep_done (sweep_done)
   );

   always #5 clk = ~clk;

   logic [DEF_DATA_W-1:0] mem    [NR];
   logic [DEF_DATA_W-1:0] preVal [NR];
   logic [DEF_DATA_W-1:0] memRd;
   logic                  preReq;

   function automatic logic [DEF_DATA_W-1:0] satInc(input logic [DEF_DATA_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Memory environment: registered read with same-edge increment forwarding, erase and strobe.
   always @(posedge clk) begin
      if (preReq) begin
         for (int k = 0; k < NR; k++) mem[k] = preVal[k];
      end else begin
         memRd = mem[bus.addrm];
         if (bus.up_snoop && bus.addr_snoop == bus.addrm) memRd = satInc(memRd);
         if (bus.up_snoop) mem[bus.addr_snoop] = satInc(mem[bus.addr_snoop]);
         if (bus.erase) mem[bus.addrm] = '0;
         bus.dato_up <= memRd;
      end
   end

   int errors = 0;
   int checks = 0;

   int  owed [NR];
   int  eraseCount [NR];
   int  accAddr [$];
   int  accCount [$];
   int  accFmt [$];
   bit  pendingOffer = 0;
   bit  ledgerLive = 0;
   bit  prevSweep = 0;
   int  prevAddrm = 0;
   int  expAddr = 0;
   int  expCount = 0;
   int  sweepCount = 0;

   function automatic logic [7:0] fmtCount(input int n);
`ifdef UP_DRAIN_BCD_EN
      int s;
      s = (n > 99) ? 99 : n;
      return 8'((s / 10) * 16 + (s % 10));
`else
      return 8'(n);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle compare against the press ledger: every press is owed to its address until delivered.
   task compareLoop();
      bit ledgerOk;
      forever begin
         @(negedge clk);
         if (reset) begin
            pendingOffer = 0;
            prevSweep    = 0;
            prevAddrm    = 0;
         end else begin
            if (ledgerLive) begin
               ledgerOk = 1;
               for (int k = 0; k < NR; k++) if (mem[k] !== 8'(owed[k])) ledgerOk = 0;
               check("ledger", 32'(ledgerOk), 32'd1);
            end
            check("adj_valid", 32'(bus.adj_valid), 32'(pendingOffer));
            if (pendingOffer && bus.adj_valid) begin
               check("adj_addr", 32'(bus.adj_addr), 32'(expAddr));
               check("adj_count", 32'(bus.adj_count), 32'(fmtCount(expCount)));
            end
            if (bus.erase) begin
               check("erase_legal",
                     32'(owed[bus.addrm] != 0 && !pendingOffer &&
                         !(bus.up_snoop && bus.addr_snoop == bus.addrm)), 32'd1);
               eraseCount[bus.addrm]++;
               expAddr  = int'(bus.addrm);
               expCount = owed[bus.addrm];
               owed[bus.addrm] = 0;
               pendingOffer = 1;
            end else if (bus.adj_valid && bus.adj_ready && pendingOffer) begin
               accAddr.push_back(expAddr);
               accCount.push_back(expCount);
               accFmt.push_back(int'(bus.adj_count));
               pendingOffer = 0;
            end
            if (bus.up_snoop && owed[bus.addr_snoop] < 255) owed[bus.addr_snoop]++;
            if (preReq) begin
               for (int k = 0; k < NR; k++) owed[k] = int'(preVal[k]);
               ledgerLive = 1;
            end
            if (sweep_done) begin
               check("sweep_done_pos", 32'(prevAddrm == NR - 1 && !prevSweep), 32'd1);
               sweepCount++;
            end
            prevSweep = sweep_done;
            prevAddrm = int'(bus.addrm);
         end
      end
   endtask

   task automatic preload(input int a0, input int v0, input int a1, input int v1);
      for (int k = 0; k < NR; k++) preVal[k] = '0;
      if (a0 >= 0) preVal[a0] = 8'(v0);
      if (a1 >= 0) preVal[a1] = 8'(v1);
      preReq = 1;
      tick(1);
      preReq = 0;
   endtask

   task automatic waitSweep();
      int s;
      int n;
      s = sweepCount;
      n = 0;
      while (sweepCount == s && n < 3000) begin
         tick(1);
         n++;
      end
      check("sweep_wait", 32'(sweepCount > s), 32'd1);
   endtask

   task automatic startSweep();
      enable = 1;
      tick(1);
      enable = 0;
   endtask

   task automatic waitValid(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.adj_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(bus.adj_valid), 32'd1);
   endtask

   function automatic int eraseTotal();
      int t;
      t = 0;
      for (int k = 0; k < NR; k++) t += eraseCount[k];
      return t;
   endfunction

   initial begin
      int n;
      int base;
      int e0;
      int e1;
      int s0;
      reset          = 1;
      enable         = 0;
      preReq         = 0;
      bus.adj_ready  = 0;
      bus.up_snoop   = 0;
      bus.addr_snoop = '0;
      for (int k = 0; k < NR; k++) begin
         preVal[k] = '0;
         owed[k] = 0;
         eraseCount[k] = 0;
      end
      fork
         compareLoop();
      join_none

      tick(2);
      check("rst_addrm", 32'(bus.addrm), 32'd0);
      check("rst_erase", 32'(bus.erase), 32'd0);
      check("rst_adj_valid", 32'(bus.adj_valid), 32'd0);
      check("rst_adj_addr", 32'(bus.adj_addr), 32'd0);
      check("rst_adj_count", 32'(bus.adj_count), 32'd0);
      check("rst_sweep_done", 32'(sweep_done), 32'd0);
      reset = 0;
      tick(1);

      $display("[TB] all-zero sweep");
      preload(-1, 0, -1, 0);
      s0 = sweepCount;
      e0 = eraseTotal();
      base = accAddr.size();
      enable = 1;
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         n++;
         #1 enable = 0;
         @(negedge clk);
         if (sweep_done) break;
      end
      check("zero_sweep_latency", 32'(n), 32'd49);
      tick(5);
      check("zero_sweep_pulses", 32'(sweepCount - s0), 32'd1);
      check("zero_sweep_erases", 32'(eraseTotal() - e0), 32'd0);
      check("zero_sweep_offers", 32'(accAddr.size() - base), 32'd0);

      $display("[TB] two offers in order");
      preload(2, 3, 9, 1);
      bus.adj_ready = 1;
      base = accAddr.size();
      e0 = eraseCount[2];
      e1 = eraseCount[9];
      startSweep();
      waitSweep();
      tick(2);
      check("two_offers_n", 32'(accAddr.size() - base), 32'd2);
      check("first_addr", 32'(accAddr[base]), 32'd2);
      check("first_count", 32'(accFmt[base]), 32'h03);
      check("second_addr", 32'(accAddr[base + 1]), 32'd9);
      check("second_count", 32'(accFmt[base + 1]), 32'h01);
      check("erase2_once", 32'(eraseCount[2] - e0), 32'd1);
      check("erase9_once", 32'(eraseCount[9] - e1), 32'd1);
      check("mem2_cleared", 32'(mem[2]), 32'd0);
      check("mem9_cleared", 32'(mem[9]), 32'd0);

      $display("[TB] collision retry");
      preload(5, 4, -1, 0);
      base = accAddr.size();
      e0 = eraseCount[5];
      startSweep();
      n = 0;
      @(negedge clk);
      while (bus.addrm != 4'd5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("reach_idx5", 32'(bus.addrm), 32'd5);
      @(posedge clk);
      #1;
      bus.up_snoop   = 1;
      bus.addr_snoop = 4'd5;
      @(negedge clk);
      check("collision_no_erase", 32'(bus.erase), 32'd0);
      @(posedge clk);
      #1 bus.up_snoop = 0;
      waitSweep();
      tick(2);
      check("collision_offers", 32'(accAddr.size() - base), 32'd1);
      check("collision_addr", 32'(accAddr[base]), 32'd5);
      check("collision_count", 32'(accFmt[base]), 32'h05);
      check("collision_erase_once", 32'(eraseCount[5] - e0), 32'd1);
      check("mem5_cleared", 32'(mem[5]), 32'd0);

      $display("[TB] stalled offer");
      preload(7, 2, -1, 0);
      bus.adj_ready = 0;
      base = accAddr.size();
      startSweep();
      waitValid("stall_valid_seen");
      for (int i = 0; i < 10; i++) begin
         check("stall_valid", 32'(bus.adj_valid), 32'd1);
         check("stall_addr", 32'(bus.adj_addr), 32'd7);
         check("stall_count", 32'(bus.adj_count), 32'h02);
         if (i < 9) @(negedge clk);
      end
      @(posedge clk);
      #1 bus.adj_ready = 1;
      @(posedge clk);
      @(negedge clk);
      check("stall_released", 32'(bus.adj_valid), 32'd0);
      waitSweep();
      tick(2);
      check("stall_offers", 32'(accAddr.size() - base), 32'd1);
      check("stall_acc_addr", 32'(accAddr[base]), 32'd7);
      check("stall_acc_count", 32'(accFmt[base]), 32'h02);

      $display("[TB] count format");
      preload(1, 150, 4, 37);
      base = accAddr.size();
      startSweep();
      waitSweep();
      tick(2);
      check("fmt_addr_a", 32'(accAddr[base]), 32'd1);
      check("fmt_addr_b", 32'(accAddr[base + 1]), 32'd4);
`ifdef UP_DRAIN_BCD_EN
      check("fmt_150", 32'(accFmt[base]), 32'h99);
      check("fmt_37", 32'(accFmt[base + 1]), 32'h37);
`else
      check("fmt_150", 32'(accFmt[base]), 32'h96);
      check("fmt_37", 32'(accFmt[base + 1]), 32'h25);
`endif

      $display("[TB] reset during offer");
      preload(3, 5, -1, 0);
      bus.adj_ready = 0;
      startSweep();
      waitValid("rst_offer_seen");
      @(posedge clk);
      #3 reset = 1;
      #1;
      check("rst_mid_valid", 32'(bus.adj_valid), 32'd0);
      check("rst_mid_addrm", 32'(bus.addrm), 32'd0);
      check("rst_mid_erase", 32'(bus.erase), 32'd0);
      @(posedge clk);
      #1 reset = 0;
      tick(2);
      check("rst_mem3_erased", 32'(mem[3]), 32'd0);
      check("rst_idle_valid", 32'(bus.adj_valid), 32'd0);

      $display("[TB] random presses and stalls");
      preload(0, 2, 15, 3);
      enable = 1;
      for (int c = 0; c < 800; c++) begin
         bus.adj_ready  = ($urandom_range(0, 9) < 6);
         bus.up_snoop   = ($urandom_range(0, 9) < 3);
         bus.addr_snoop = 4'($urandom_range(0, NR - 1));
         tick(1);
      end
      bus.up_snoop  = 0;
      bus.adj_ready = 1;
      waitSweep();
      waitSweep();
      enable = 0;
      waitSweep();
      tick(3);
      for (int k = 0; k < NR; k++) begin
         check("drain_owed", 32'(owed[k]), 32'd0);
         check("drain_mem", 32'(mem[k]), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
